block_ram_sdp: RTL
==================

# block_ram_sdp

Parametrised simple-dual-port block RAM with one write port and one read port. It adds per-byte write enables, a selectable output register, defined read-during-write behaviour, and a power-on/reset scrub that fills every word with a constant. It replaces fixed-geometry 32-bit RAM wrappers in the instruction/data memory and video-buffer paths of the SoC, and is inferred from generic RTL rather than a vendor primitive.

## Interface

- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 13, address width; depth = 2^ADDR_WIDTH words
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
- BYPASS, 1, 1 = write-first on address collision; 0 = read-first (old data)
- SCRUB_ON_RESET, 1, 1 = fill the whole array after reset; 0 = array untouched, ready immediately
- FILL_VALUE, {DATA_WIDTH{1'b1}}, word written by the scrub

Ports:

- clk  in  1  single clock; all logic on rising edge
- rstn  in  1  synchronous reset, active-low
- busy  out  1  high while scrubbing; user accesses ignored
- wrEn  in  1  write request
- wrAddr  in  ADDR_WIDTH  write address
- wrByteEn  in  DATA_WIDTH/8  byte-lane enables; bit i covers wrData[8i+7:8i]
- wrData  in  DATA_WIDTH  write data
- rdEn  in  1  read request
- rdAddr  in  ADDR_WIDTH  read address
- rdData  out  DATA_WIDTH  read data; holds its last value between reads
- rdValid  out  1  one-cycle pulse marking new rdData

## Operation

- Control FSM states: SCRUB and READY.
- On rstn low at a clock edge: state goes to SCRUB if SCRUB_ON_RESET=1, otherwise to READY.
- Reset also applies these values: scrub counter = 0, busy = SCRUB_ON_RESET, rdData = 0, rdValid = 0, and the OUT_REG pipeline is cleared.
- SCRUB: each cycle writes FILL_VALUE with all byte lanes to address scrubCnt, then increments scrubCnt.
- SCRUB exit: after the write to address 2^ADDR_WIDTH-1, the next state is READY. The counter must not wrap into a second pass.
- While in SCRUB, wrEn and rdEn are ignored: no array change from the user port, and rdValid stays 0.
- Reset asserted mid-scrub restarts the scrub from address 0.
- READY, write: when wrEn=1, each lane with wrByteEn[i]=1 is updated and the other lanes are preserved. wrByteEn=0 is a no-op.
- READY, read: when rdEn=1, the word at rdAddr is read.
- Collision (rdEn and wrEn in the same cycle, rdAddr == wrAddr):
  - BYPASS=1: returned word = enabled lanes from wrData, remaining lanes from the old word.
  - BYPASS=0: returned word = entire old word.
- No read issued: rdData holds, rdValid = 0.

## Timing

- OUT_REG=0: rdEn sampled at edge N; rdData and rdValid updated at edge N+1.
- OUT_REG=1: same, updated at edge N+2. The pipeline is fully pipelined, so back-to-back reads every cycle give a continuous rdValid.
- A write at edge N is visible to a non-colliding read issued at edge N+1 or later.
- Scrub duration: busy is high for exactly 2^ADDR_WIDTH cycles after the reset-release edge.
  - The first user access is accepted on the first edge where busy=0.
- Reads issued on the final SCRUB cycle are dropped (busy is still 1).
- A read already in the OUT_REG pipeline when rstn asserts is discarded: no rdValid pulse.

## Test plan

- Scrub, ADDR_WIDTH=4, FILL_VALUE=32'hFFFFFFFF: release rstn -> busy high for 16 cycles. Then reading addresses 0..15 returns FFFFFFFF, each with one rdValid pulse one cycle after rdEn.
- Byte lanes: write 32'h11223344 to address 5 with wrByteEn=4'b1111, then write 32'hAABBCCDD with wrByteEn=4'b0101 -> read of address 5 returns 32'h11BB33DD. A write with wrByteEn=0 leaves it unchanged.
- Collision: address 7 holds 32'h0 -> same-cycle write of 32'hCAFEBABE (all lanes) and read of address 7 returns CAFEBABE with BYPASS=1 and 00000000 with BYPASS=0.
- Reset mid-scrub: assert rstn low at scrub cycle 9, release -> busy high a full 16 cycles again. Writes and reads issued while busy cause no rdValid and no array change.
- OUT_REG=1: back-to-back reads of addresses 1, 2, 3 on consecutive cycles -> rdValid high on edges N+2..N+4 with the matching data. rdData holds its value afterwards.
- SCRUB_ON_RESET=0: after reset busy=0 immediately, rdData=0, and a write followed by a read at edge+1 returns the written data.

Source files
------------

// File: rtl/block_ram_sdp.sv
// block_ram_sdp: simple-dual-port RAM (1 write, 1 read) with byte-lane write enables and a post-reset fill.
// Latency: rdData/rdValid update 1 edge after the edge that samples rdEn (2 with OUT_REG=1); writes visible next edge.
// Backpressure: none; busy=1 while the fill runs, and user reads/writes offered then are dropped, not stalled.
//
// Ports:
//   clk, rstn            single rising-edge clock, synchronous active-low reset
//   busy                 high while the array is being filled with FILL_VALUE
//   wrEn/wrAddr/wrByteEn/wrData   write port; byte lane i covers wrData[8i+7:8i]
//   rdEn/rdAddr          read request
//   rdData/rdValid       read result; rdData holds between reads, rdValid pulses once per read
module block_ram_sdp #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 13,
  parameter int                    OUT_REG        = 0,
  parameter int                    BYPASS         = 1,
  parameter int                    SCRUB_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE     = {DATA_WIDTH{1'b1}}
) (
  input  logic                    clk,
  input  logic                    rstn,
  output logic                    busy,
  input  logic                    wrEn,
  input  logic [ADDR_WIDTH-1:0]   wrAddr,
  input  logic [DATA_WIDTH/8-1:0] wrByteEn,
  input  logic [DATA_WIDTH-1:0]   wrData,
  input  logic                    rdEn,
  input  logic [ADDR_WIDTH-1:0]   rdAddr,
  output logic [DATA_WIDTH-1:0]   rdData,
  output logic                    rdValid
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    S_SCRUB,
    S_READY
  } state_t;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_scrub_cnt;
  logic [ADDR_WIDTH-1:0] w_scrub_cnt_nxt;

  logic                  w_busy;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [NB-1:0]         w_mem_be;
  logic [DATA_WIDTH-1:0] w_mem_din;
  logic                  w_rd_acc;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= (SCRUB_ON_RESET != 0) ? S_SCRUB : S_READY;
      r_scrub_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_scrub_cnt <= w_scrub_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_scrub_cnt_nxt = r_scrub_cnt;
    w_busy          = 1'b0;
    w_mem_we        = 1'b0;
    w_mem_addr      = wrAddr;
    w_mem_be        = wrByteEn;
    w_mem_din       = wrData;
    w_rd_acc        = 1'b0;
    case (r_state)
      S_SCRUB: begin
        w_busy     = 1'b1;
        // Array writes are gated with rstn because the array itself has no
        // reset: nothing may land in it while reset is being held.
        w_mem_we   = rstn;
        w_mem_addr = r_scrub_cnt;
        w_mem_be   = '1;
        w_mem_din  = FILL_VALUE;
        // Leave on the last address instead of wrapping into a second pass.
        if (r_scrub_cnt == {ADDR_WIDTH{1'b1}}) begin
          w_state_nxt = S_READY;
        end else begin
          w_scrub_cnt_nxt = ADDR_WIDTH'(r_scrub_cnt + 1'b1);
        end
      end
      S_READY: begin
        w_mem_we = rstn && wrEn;
        w_rd_acc = rstn && rdEn;
      end
      default: begin
        w_state_nxt = S_READY;
      end
    endcase
  end

  assign busy = w_busy;

  // ---------------------------------------------------------------------------
  // Storage array: one write port with byte lanes, one registered read port.
  // The read register always captures the pre-write word (read-first array);
  // write-first behaviour is rebuilt afterwards by overlaying the colliding
  // write lanes, which keeps the array itself a plain inferable SDP RAM.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (w_mem_be[i]) begin
          r_mem[w_mem_addr][8*i +: 8] <= w_mem_din[8*i +: 8];
        end
      end
    end
  end

  logic                  w_col;
  logic [NB-1:0]         w_ovr;
  logic [DATA_WIDTH-1:0] r_a_raw;
  logic [NB-1:0]         r_a_ovr;
  logic [DATA_WIDTH-1:0] r_a_wdat;
  logic                  r_a_vld;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_col = w_rd_acc && wrEn && (rdAddr == wrAddr);
  // Lanes to take from the write port; all-zero means "return the old word".
  assign w_ovr = ((BYPASS != 0) && w_col) ? wrByteEn : '0;

  always_ff @(posedge clk) begin
    if (w_rd_acc) begin
      r_a_raw  <= r_mem[rdAddr];
      r_a_ovr  <= w_ovr;
      r_a_wdat <= wrData;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_a_vld <= 1'b0;
    end else begin
      r_a_vld <= w_rd_acc;
    end
  end

  always_comb begin
    w_merged = r_a_raw;
    for (int i = 0; i < NB; i++) begin
      if (r_a_ovr[i]) begin
        w_merged[8*i +: 8] = r_a_wdat[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage(s). rdData only loads on a valid word so it holds otherwise.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_rd_dat;
  logic                  r_rd_vld;

  if (OUT_REG != 0) begin : g_out_reg
    logic                  r_b_vld;
    logic [DATA_WIDTH-1:0] r_b_dat;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_b_vld  <= 1'b0;
        r_b_dat  <= '0;
        r_rd_vld <= 1'b0;
        r_rd_dat <= '0;
      end else begin
        r_b_vld <= r_a_vld;
        if (r_a_vld) begin
          r_b_dat <= w_merged;
        end
        r_rd_vld <= r_b_vld;
        if (r_b_vld) begin
          r_rd_dat <= r_b_dat;
        end
      end
    end
  end else begin : g_no_out_reg
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_rd_vld <= 1'b0;
        r_rd_dat <= '0;
      end else begin
        r_rd_vld <= r_a_vld;
        if (r_a_vld) begin
          r_rd_dat <= w_merged;
        end
      end
    end
  end

  assign rdData  = r_rd_dat;
  assign rdValid = r_rd_vld;

endmodule
